// File: rtl/vic_bus_pkg.sv
// vic_bus_pkg: shared direction-FSM state type and parameter defaults for the VIC bus interface
package vic_bus_pkg;
    localparam int ADDR_W_DEF   = 12;
    localparam int ADI_W_DEF    = 6;
    localparam int DBO_W_DEF    = 8;
    localparam int DBI_W_DEF    = 12;
    localparam int TURN_CYC_DEF = 2;
    localparam int WR_DLY_DEF   = 4;

    typedef enum logic [1:0] {
        DIR_IDLE,
        DIR_TURN_ON,
        DIR_DRIVE,
        DIR_TURN_OFF
    } dir_state_e;
endpackage

// File: rtl/vic_bus_if_dir_fsm.sv
// bus_dir_fsm: one bus direction controller with TURN_CYC dead cycles on each turnaround
module bus_dir_fsm
    import vic_bus_pkg::*;
#(
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic clk_dot4x,
    input  logic rst_n,
    input  logic req,
    output logic oe
);
    localparam logic [2:0] LAST      = (TURN_CYC == 0) ? 3'd0 : 3'(TURN_CYC - 1);
    localparam logic       ZERO_TURN = (TURN_CYC == 0);

    dir_state_e state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    // state and dead-cycle counter register; reset drops straight to idle
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // turnaround sequencing; counter restarts at zero whenever a state is entered
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            DIR_IDLE:     if (req) state_nxt = ZERO_TURN ? DIR_DRIVE : DIR_TURN_ON;
            DIR_TURN_ON:  if (!req) state_nxt = DIR_IDLE;
                          else if (cnt == LAST) state_nxt = DIR_DRIVE;
                          else cnt_nxt = cnt + 3'd1;
            DIR_DRIVE:    if (!req) state_nxt = ZERO_TURN ? DIR_IDLE : DIR_TURN_OFF;
            DIR_TURN_OFF: if (cnt == LAST) state_nxt = DIR_IDLE;
                          else cnt_nxt = cnt + 3'd1;
            default:      state_nxt = DIR_IDLE;
        endcase
    end

    // enable only in the drive state, so it follows the async reset immediately
    always_comb oe = (state == DIR_DRIVE);
endmodule

// File: rtl/vic_bus_if.sv
// vic_bus_if: VIC pad-side bus interface (direction control, CPU register access); BUS_CONTENTION_DETECT_EN adds a sticky contention flag
module vic_bus_if
    import vic_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ADI_W    = ADI_W_DEF,
    parameter int DBO_W    = DBO_W_DEF,
    parameter int DBI_W    = DBI_W_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF,
    parameter int WR_DLY   = WR_DLY_DEF
) (
    input  logic              clk_dot4x,
    input  logic              rst_n,
    input  logic              req_ab,
    input  logic              req_db,
    input  logic [ADDR_W-1:0] ado,
    input  logic [DBO_W-1:0]  dbo,
    input  logic [ADI_W-1:0]  adi_pin,
    input  logic [DBI_W-1:0]  dbi_pin,
    input  logic              ce_pin,
    input  logic              rw_pin,
    output logic              ab_oe,
    output logic [ADDR_W-1:0] ab_out,
    output logic              db_oe,
    output logic [DBO_W-1:0]  db_out,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic [ADI_W-1:0]  reg_addr,
    output logic [DBI_W-1:0]  reg_wdata,
    output logic              contention
);
    localparam logic [3:0] WR_LAST = 4'(WR_DLY - 1);
    localparam logic       WR_ONE  = (WR_DLY == 1);

    logic       ce_q1, ce_s, ce_d, rw_q1, rw_s;
    logic       wr_act;
    logic [3:0] wcnt;
    logic       fall, wr_hit;

    bus_dir_fsm #(.TURN_CYC(TURN_CYC)) u_ab_fsm (
        .clk_dot4x(clk_dot4x), .rst_n(rst_n), .req(req_ab), .oe(ab_oe)
    );

    bus_dir_fsm #(.TURN_CYC(TURN_CYC)) u_db_fsm (
        .clk_dot4x(clk_dot4x), .rst_n(rst_n), .req(req_db), .oe(db_oe)
    );

    assign fall   = ce_d & ~ce_s;
    assign wr_hit = ~ce_s & ((fall & ~rw_s & WR_ONE) | (wr_act & (wcnt == WR_LAST)));

    // pin synchronisers (idle high) and the registered pad data path
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            ce_q1  <= 1'b1;
            ce_s   <= 1'b1;
            ce_d   <= 1'b1;
            rw_q1  <= 1'b1;
            rw_s   <= 1'b1;
            ab_out <= '0;
            db_out <= '0;
        end else begin
            ce_q1  <= ce_pin;
            ce_s   <= ce_q1;
            ce_d   <= ce_s;
            rw_q1  <= rw_pin;
            rw_s   <= rw_q1;
            ab_out <= ado;
            db_out <= dbo;
        end
    end

    // CPU access: direction sampled once at select, write data taken after WR_DLY selected cycles
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            wr_act    <= 1'b0;
            wcnt      <= '0;
        end else begin
            reg_rd <= fall & rw_s;
            reg_wr <= wr_hit;
            if (fall) reg_addr <= adi_pin;
            if (wr_hit) reg_wdata <= dbi_pin;
            if (fall & ~rw_s & ~WR_ONE) begin
                wr_act <= 1'b1;
                wcnt   <= 4'd1;
            end else if (wr_act & (ce_s | (wcnt == WR_LAST))) begin
                wr_act <= 1'b0;
                wcnt   <= '0;
            end else if (wr_act) begin
                wcnt <= wcnt + 4'd1;
            end
        end
    end

`ifdef BUS_CONTENTION_DETECT_EN
    // sticky flag: we drive the data bus while the CPU is writing into us
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) contention <= 1'b0;
        else contention <= contention | (db_oe & ~ce_s & ~rw_s);
    end
`else
    assign contention = 1'b0;
`endif
endmodule

// File: tb/tb_vic_bus_if.sv
// tb_vic_bus_if: randomized self-checking bench for vic_bus_if against a timestamp-based reference model
module tb_vic_bus_if;
    localparam int TURN_CYC = 2;
    localparam int WR_DLY   = 4;
`ifdef BUS_CONTENTION_DETECT_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    logic clk = 0, rst_n = 0;
    logic req_ab = 0, req_db = 0;
    logic [11:0] ado = 0;
    logic [7:0] dbo = 0;
    logic [5:0] adi_pin = 0;
    logic [11:0] dbi_pin = 0;
    logic ce_pin = 1, rw_pin = 1;
    logic ab_oe, db_oe, reg_rd, reg_wr, contention;
    logic [11:0] ab_out;
    logic [7:0] db_out;
    logic [5:0] reg_addr;
    logic [11:0] reg_wdata;

    int n_tests = 0, n_fail = 0;
    int tcur = 0, rd_cnt = 0, wr_cnt = 0;
    bit drv[2], pend[2];
    int on_at[2], free_at[2];
    logic [11:0] exp_ab_out, m_wdata;
    logic [7:0] exp_db_out;

    vic_bus_if #(.ADDR_W(12), .ADI_W(6), .DBO_W(8), .DBI_W(12),
                 .TURN_CYC(TURN_CYC), .WR_DLY(WR_DLY)) dut (
        .clk_dot4x(clk), .rst_n(rst_n), .req_ab(req_ab), .req_db(req_db),
        .ado(ado), .dbo(dbo), .adi_pin(adi_pin), .dbi_pin(dbi_pin),
        .ce_pin(ce_pin), .rw_pin(rw_pin), .ab_oe(ab_oe), .ab_out(ab_out),
        .db_oe(db_oe), .db_out(db_out), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .contention(contention)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // bus timing as timestamps: drive starts TURN_CYC edges after a granted request,
    // a new request is honoured only TURN_CYC+1 edges after drive stops
    function automatic void model_edge(int b, bit r);
        if (drv[b]) begin
            if (!r) begin
                drv[b] = 0;
                free_at[b] = tcur + TURN_CYC + 1;
            end
        end else if (pend[b]) begin
            if (!r) pend[b] = 0;
            else if (tcur == on_at[b]) begin
                pend[b] = 0;
                drv[b] = 1;
            end
        end else if (r && tcur >= free_at[b]) begin
            if (TURN_CYC == 0) drv[b] = 1;
            else begin
                pend[b] = 1;
                on_at[b] = tcur + TURN_CYC;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            drv[b] = 0; pend[b] = 0; free_at[b] = 0; on_at[b] = 0;
        end
        m_wdata = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        tcur++;
        exp_ab_out = ado;
        exp_db_out = dbo;
        model_edge(0, req_ab);
        model_edge(1, req_db);
        #1;
        rd_cnt += int'(reg_rd);
        wr_cnt += int'(reg_wr);
    endtask

    task automatic cpu_access(input bit rw, input logic [5:0] a, input logic [11:0] d,
                              input int len, input bit flip);
        rd_cnt = 0; wr_cnt = 0;
        rw_pin = rw; adi_pin = a; dbi_pin = d; ce_pin = 0;
        for (int i = 0; i < len; i++) begin
            if (flip && i == 2) rw_pin = ~rw;
            step();
        end
        ce_pin = 1;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if ({ab_oe, db_oe, reg_rd, reg_wr, contention} !== 5'b0 || reg_addr !== 0 ||
            reg_wdata !== 0 || ab_out !== 0 || db_out !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: oe=%b%b rd=%b wr=%b cont=%b addr=%h wdata=%h ab=%h db=%h, want all 0",
                     ab_oe, db_oe, reg_rd, reg_wr, contention, reg_addr, reg_wdata, ab_out, db_out);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_db_timing();
        for (int c = 0; c < 32; c++) begin
            req_db = ((c >= 10 && c < 20) || c >= 22);
            step();
            n_tests++;
            if (db_oe !== (((c + 1) >= 13 && (c + 1) < 21) || (c + 1) >= 26)) begin
                n_fail++;
                $display("FAIL db_timing cycle %0d: db_oe=%b want %b", c + 1, db_oe,
                         ((c + 1) >= 13 && (c + 1) < 21) || (c + 1) >= 26);
            end
        end
        req_db = 0;
        repeat (6) step();
    endtask

    task automatic test_random_bus();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) req_ab = ~req_ab;
            if ($urandom_range(0, 5) == 0) req_db = ~req_db;
            ado = 12'($urandom);
            dbo = 8'($urandom);
            step();
            n_tests++;
            if (ab_oe !== drv[0] || db_oe !== drv[1] || ab_out !== exp_ab_out || db_out !== exp_db_out) begin
                n_fail++;
                $display("FAIL random_bus t=%0d: ab_oe=%b db_oe=%b ab_out=%h db_out=%h want %b %b %h %h",
                         tcur, ab_oe, db_oe, ab_out, db_out, drv[0], drv[1], exp_ab_out, exp_db_out);
            end
        end
        req_ab = 0; req_db = 0;
        repeat (8) step();
    endtask

    task automatic test_read();
        cpu_access(1, 6'h20, 12'h000, 4, 0);
        n_tests++;
        if (rd_cnt != 1 || wr_cnt != 0 || reg_addr !== 6'h20) begin
            n_fail++;
            $display("FAIL read: rd_pulses=%0d wr_pulses=%0d addr=%h want 1 0 20", rd_cnt, wr_cnt, reg_addr);
        end
    endtask

    task automatic test_write();
        cpu_access(0, 6'h11, 12'hA5F, 8, 0);
        m_wdata = 12'hA5F;
        n_tests++;
        if (wr_cnt != 1 || rd_cnt != 0 || reg_wdata !== 12'hA5F || reg_addr !== 6'h11) begin
            n_fail++;
            $display("FAIL write: wr_pulses=%0d rd_pulses=%0d wdata=%h addr=%h want 1 0 a5f 11",
                     wr_cnt, rd_cnt, reg_wdata, reg_addr);
        end
    endtask

    task automatic test_abort();
        cpu_access(0, 6'h05, 12'h123, 3, 0);
        n_tests++;
        if (wr_cnt != 0 || reg_wdata !== 12'hA5F) begin
            n_fail++;
            $display("FAIL abort: wr_pulses=%0d wdata=%h want 0 a5f", wr_cnt, reg_wdata);
        end
    endtask

    task automatic test_random_cpu();
        for (int k = 0; k < 30; k++) begin
            bit rw, flip;
            logic [5:0] a;
            logic [11:0] d;
            int len, ew;
            rw = 1'($urandom); flip = 1'($urandom);
            a = 6'($urandom); d = 12'($urandom);
            len = $urandom_range(1, 10);
            cpu_access(rw, a, d, len, flip);
            ew = (!rw && len >= WR_DLY) ? 1 : 0;
            if (ew == 1) m_wdata = d;
            n_tests++;
            if (rd_cnt != int'(rw) || wr_cnt != ew || reg_addr !== a || reg_wdata !== m_wdata || contention !== 1'b0) begin
                n_fail++;
                $display("FAIL random_cpu #%0d rw=%b len=%0d: rd=%0d wr=%0d addr=%h wdata=%h cont=%b want %0d %0d %h %h 0",
                         k, rw, len, rd_cnt, wr_cnt, reg_addr, reg_wdata, contention, rw, ew, a, m_wdata);
            end
        end
    endtask

    task automatic test_contention();
        int n;
        req_db = 1;
        n = 0;
        while (db_oe !== 1'b1 && n < 20) begin step(); n++; end
        n_tests++;
        if (db_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_setup: db_oe=%b want 1 within 20 cycles", db_oe);
        end
        cpu_access(0, 6'h01, 12'h0F0, 6, 0);
        n_tests++;
        if (contention !== CONT_EN) begin
            n_fail++;
            $display("FAIL contention_set: contention=%b want %b", contention, CONT_EN);
        end
        req_db = 0;
        repeat (10) step();
        n_tests++;
        if (contention !== CONT_EN) begin
            n_fail++;
            $display("FAIL contention_sticky: contention=%b want %b", contention, CONT_EN);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if (contention !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_clear: contention=%b want 0", contention);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (4) step();
    endtask

    task automatic test_reset_mid_drive();
        int n;
        req_ab = 1;
        n = 0;
        while (ab_oe !== 1'b1 && n < 20) begin step(); n++; end
        n_tests++;
        if (ab_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_drive_setup: ab_oe=%b want 1 within 20 cycles", ab_oe);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if ({ab_oe, db_oe, reg_rd, reg_wr, contention} !== 5'b0 || reg_addr !== 0 ||
            reg_wdata !== 0 || ab_out !== 0 || db_out !== 0) begin
            n_fail++;
            $display("FAIL async_reset: ab_oe=%b db_oe=%b addr=%h wdata=%h ab=%h db=%h want all 0",
                     ab_oe, db_oe, reg_addr, reg_wdata, ab_out, db_out);
        end
        @(negedge clk);
        rst_n = 1;
        n = 0;
        while (ab_oe !== 1'b1 && n < 20) begin step(); n++; end
        n_tests++;
        if (n != TURN_CYC + 1) begin
            n_fail++;
            $display("FAIL post_reset_latency: ab_oe after %0d cycles want %0d", n, TURN_CYC + 1);
        end
        req_ab = 0;
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_db_timing();
        test_random_bus();
        test_read();
        test_write();
        test_abort();
        test_random_cpu();
        test_contention();
        test_reset_mid_drive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vic_bus_if.md
VIC_BUS_IF -- requirements
Module: vic_bus_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning width of the driven address bus.
REQ-002 SHALL have parameter ADI_W, default 6, meaning number of address bits sampled on CPU register access.
REQ-003 SHALL have parameter DBO_W, default 8, meaning width of the driven data bus.
REQ-004 SHALL have parameter DBI_W, default 12, meaning width of the sampled data bus (data plus colour nibble).
REQ-005 SHALL have parameter TURN_CYC, default 2, range 0..7, meaning dead cycles at each bus direction change.
REQ-006 SHALL have parameter WR_DLY, default 4, range 1..15, meaning cycles from CPU write start to data capture.
REQ-007 SHALL have ports, in order:
  - clk_dot4x  in  1  sole clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - req_ab  in  1  core requests address-bus drive.
  - req_db  in  1  core requests data-bus drive.
  - ado  in  ADDR_W  core address.
  - dbo  in  DBO_W  core data.
  - adi_pin  in  ADI_W  address pad input.
  - dbi_pin  in  DBI_W  data pad input.
  - ce_pin  in  1  chip enable, low = selected, asynchronous.
  - rw_pin  in  1  high = read, low = write, asynchronous.
  - ab_oe  out  1  address pad output enable.
  - ab_out  out  ADDR_W  registered address to pads.
  - db_oe  out  1  data pad output enable.
  - db_out  out  DBO_W  registered data to pads.
  - reg_rd  out  1  one-cycle CPU read strobe.
  - reg_wr  out  1  one-cycle CPU write strobe.
  - reg_addr  out  ADI_W  latched register address.
  - reg_wdata  out  DBI_W  captured write data.
  - contention  out  1  sticky bus-contention flag.

Function
REQ-008 SHALL pass ce_pin and rw_pin through 2-flop synchronisers; "ce_s"/"rw_s" below mean synchronised values.
REQ-009 SHALL register ado->ab_out and dbo->db_out every cycle, independent of enables.
REQ-010 SHALL run one direction FSM per bus (address: req_ab/ab_oe; data: req_db/db_oe), states IDLE, TURN_ON, DRIVE, TURN_OFF.
REQ-011 IDLE: oe=0; req=1 -> TURN_ON (or directly DRIVE when TURN_CYC=0).
REQ-012 TURN_ON: oe=0 for exactly TURN_CYC cycles, then DRIVE; req dropping during TURN_ON -> IDLE immediately.
REQ-013 DRIVE: oe=1; req=0 -> oe=0 on next edge and TURN_OFF (or IDLE when TURN_CYC=0).
REQ-014 TURN_OFF: oe=0 for exactly TURN_CYC cycles, req ignored, then IDLE; pending req then starts a fresh TURN_ON.
REQ-015 Latency: req rise to oe=1 SHALL be TURN_CYC+1 cycles; req fall to oe=0 SHALL be 1 cycle.
REQ-016 On ce_s 1->0: SHALL latch adi_pin into reg_addr and sample rw_s in the same cycle.
REQ-017 Read (rw_s=1): reg_rd SHALL pulse for one cycle, the cycle after the ce_s falling edge.
REQ-018 Write (rw_s=0): an access counter SHALL count WR_DLY cycles; at expiry it SHALL capture dbi_pin into reg_wdata and pulse reg_wr for one cycle.
REQ-019 If ce_s returns to 1 before WR_DLY expires, the write SHALL abort: no reg_wr, reg_wdata unchanged.
REQ-020 One strobe per ce_s low period; rw_s changes while ce_s=0 SHALL be ignored.
REQ-021 reg_addr and reg_wdata SHALL hold their values until the next access.

Reset
REQ-022 While rst_n=0: ab_oe=db_oe=0, both FSMs in IDLE, reg_rd=reg_wr=0, reg_addr=0, reg_wdata=0, ab_out=0, db_out=0, contention=0, access counter=0, synchroniser flops=1.
REQ-023 Reset mid-drive SHALL drop oe asynchronously, with no TURN_OFF sequence.
REQ-024 After rst_n deassertion, an asserted req SHALL take the full TURN_CYC+1 latency.

Configuration
REQ-025 Macro BUS_CONTENTION_DETECT_EN defined: contention SHALL set when db_oe=1 while ce_s=0 and rw_s=0, and clear only on reset.
REQ-026 Macro BUS_CONTENTION_DETECT_EN undefined: contention SHALL be constant 0 and the detection logic SHALL NOT be present.

Structure
REQ-027 Package vic_bus_pkg SHALL hold the direction-FSM state enum and the parameter defaults.
REQ-028 Sub-module bus_dir_fsm, parametrised by TURN_CYC, SHALL implement REQ-010..REQ-015 and be instantiated twice.
REQ-029 Tri-state pad muxing SHALL stay in the board top level; this block outputs enables only.

Verification
REQ-030 TURN_CYC=2, req_db rises at cycle 10 -> db_oe=1 at cycle 13; req_db falls at cycle 20 -> db_oe=0 at cycle 21; re-request at cycle 22 -> db_oe=1 at cycle 26.
REQ-031 ce_pin low with rw_pin=1, adi_pin=6'h20 -> reg_rd pulses once; reg_addr=6'h20; no reg_wr.
REQ-032 WR_DLY=4, write with dbi_pin=12'hA5F held, ce_pin low 8 cycles -> one reg_wr pulse, reg_wdata=12'hA5F.
REQ-033 Write with ce_pin low only 3 synchronised cycles -> no reg_wr; reg_wdata keeps its prior value.
REQ-034 rst_n pulsed low while ab_oe=1 -> ab_oe=0 with no clock edge; all outputs at reset values.
REQ-035 BUS_CONTENTION_DETECT_EN defined, db_oe=1 during a CPU write -> contention=1 and stays 1 until rst_n; macro undefined -> contention=0 throughout.
